dmem_resp: RTL and testbench

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/cpu_32_pkg.sv | 34 +++
 rtl/dmem_ram.sv | 42 ++++
 rtl/dmem_resp.sv | 203 ++++++++++++++++++++
 tb/tb_dmem_resp.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_32_pkg.sv
// ---------------------------------------------------------------------------
// cpu_32 -- shared definitions for the CPU data-memory slice.
//
// Contents:
//   dmem_state_e  : response-unit FSM states (RUN, FLUSH)
//   WBUF_DEPTH    : number of posted-write buffer entries
//   WBUF_PTR_W    : width of the buffer head/tail pointers
//   WBUF_CNT_W    : width of the buffer occupancy counter
//   wbuf_entry_t  : one posted write {word address, data}
//   is_aligned()  : true when a byte address is word aligned
// ---------------------------------------------------------------------------
package cpu_32;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } dmem_state_e;

    localparam int WBUF_DEPTH = 2;
    localparam int WBUF_PTR_W = 1;
    localparam int WBUF_CNT_W = 2;

    // The word address is kept zero-extended to 32 bits so the record does
    // not depend on the RAM depth parameter of any particular instance.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wbuf_entry_t;

    function automatic logic is_aligned(input logic [1:0] lowBits);
        return (lowBits == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// ---------------------------------------------------------------------------
// dmem_ram -- single-port 2^AW x 32 RAM with a one-cycle registered read.
//
// Ports:
//   clk     : clock
//   i_en    : port enable (read or write this cycle)
//   i_we    : write when set, read otherwise
//   i_addr  : word address
//   i_wdata : write data
//   o_rdata : read data, valid the cycle after a read; holds its value
//             across writes and idle cycles
// ---------------------------------------------------------------------------
module dmem_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [0:(1<<AW)-1];
    logic [31:0] r_rdata;

    // Storage has no reset on purpose: memory contents survive a reset of
    // the surrounding logic. The read register only moves on a read so the
    // last read word stays visible.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_resp.sv
// ---------------------------------------------------------------------------
// dmem_resp -- data-memory responder with a 2-entry posted write buffer.
//
// Writes are posted into a small FIFO and drained to the RAM whenever the
// RAM port is not needed by a read. Reads search the buffer first (youngest
// match wins) and fall back to the RAM; either way the response appears one
// cycle after acceptance. A flush pulse stalls new requests until the buffer
// is empty and then pulses flush_done.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   dm_cs      : request valid
//   dm_r       : read enable (reads are decoded as dm_cs & ~dm_w)
//   dm_w       : write request, wins over dm_r
//   addr       : byte address, bits [AW+1:2] select the word
//   wdata      : write data
//   flush      : one-cycle drain request
//   ready      : request accepted when dm_cs & ready
//   rdata      : read data, held while rvalid is low
//   rvalid     : rdata valid this cycle
//   err        : one-cycle pulse after a misaligned request
//   flush_done : one-cycle pulse once the buffer has emptied after a flush
// ---------------------------------------------------------------------------
module dmem_resp
    import cpu_32::*;
#(
    parameter int AW = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dm_cs,
    input  logic        dm_r,
    input  logic        dm_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        err,
    output logic        flush_done
);

    dmem_state_e              r_state;
    wbuf_entry_t              r_buf [WBUF_DEPTH];
    logic [WBUF_PTR_W-1:0]    r_head;
    logic [WBUF_PTR_W-1:0]    r_tail;
    logic [WBUF_CNT_W-1:0]    r_count;
    logic                     r_rvalid;
    logic                     r_err;
    logic                     r_flushDone;
    logic                     r_useFwd;
    logic [31:0]              r_fwdData;
    logic [31:0]              r_rdataHold;

    logic                     w_accept;
    logic                     w_aligned;
    logic [31:0]              w_wordAddr;
    logic                     w_wrAcc;
    logic                     w_rdAcc;
    logic                     w_hit;
    logic [31:0]              w_hitData;
    logic [WBUF_PTR_W-1:0]    w_fwdIdx;
    logic                     w_ramRead;
    logic                     w_push;
    logic                     w_pop;
    logic [WBUF_CNT_W-1:0]    w_countNext;
    logic                     w_ramEn;
    logic [AW-1:0]            w_ramAddr;
    logic [31:0]              w_ramDout;
    wbuf_entry_t              w_headEntry;

    // dm_r is redundant with the dm_w-based decode and the upper address
    // bits wrap away; they are collected here only to mark them as unused.
    logic w_unused;
    assign w_unused = &{1'b0, dm_r, addr[31:AW+2]};

    // Request decode. Misaligned requests are accepted but do nothing except
    // raise err.
    assign w_accept   = dm_cs & ready;
    assign w_aligned  = is_aligned(addr[1:0]);
    assign w_wordAddr = 32'(addr[AW+1:2]);
    assign w_wrAcc    = w_accept & dm_w & w_aligned;
    assign w_rdAcc    = w_accept & ~dm_w & w_aligned;

    // Ready looks only at the current occupancy, so a write to a full buffer
    // stalls even if the head would drain this cycle.
    assign ready = (r_state == ST_RUN) &
                   ~((r_count == WBUF_CNT_W'(WBUF_DEPTH)) & dm_w);

    // Forwarding search walks from oldest to youngest so the last match,
    // i.e. the youngest write, is the one that sticks. It looks at the buffer
    // before any pop of this cycle.
    always_comb begin
        w_hit     = 1'b0;
        w_hitData = '0;
        w_fwdIdx  = r_head;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            w_fwdIdx = r_head + WBUF_PTR_W'(i);
            if ((WBUF_CNT_W'(i) < r_count) && (r_buf[w_fwdIdx].addr == w_wordAddr)) begin
                w_hit     = 1'b1;
                w_hitData = r_buf[w_fwdIdx].data;
            end
        end
    end

    // The RAM port goes to a read that missed the buffer; otherwise the head
    // entry drains. Nothing drains while reset is held so buffered writes
    // are really discarded.
    assign w_headEntry = r_buf[r_head];
    assign w_ramRead   = w_rdAcc & ~w_hit;
    assign w_pop       = ~rst & ~w_ramRead & (r_count != '0);
    assign w_push      = w_wrAcc;
    assign w_countNext = r_count + WBUF_CNT_W'(w_push) - WBUF_CNT_W'(w_pop);
    assign w_ramEn     = w_ramRead | w_pop;
    assign w_ramAddr   = w_pop ? w_headEntry.addr[AW-1:0] : w_wordAddr[AW-1:0];

    dmem_ram #(
        .AW(AW)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ramEn),
        .i_we    (w_pop),
        .i_addr  (w_ramAddr),
        .i_wdata (w_headEntry.data),
        .o_rdata (w_ramDout)
    );

    // Write buffer FIFO: push at the tail, pop at the head, both allowed in
    // the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_buf[r_tail] <= '{addr: w_wordAddr, data: wdata};
                r_tail        <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            r_count <= w_countNext;
        end
    end

    // RUN/FLUSH controller. flush_done fires on the edge where the buffer
    // becomes empty; an already-empty buffer completes straight from RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_flushDone <= 1'b0;
        end else begin
            r_flushDone <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (flush) begin
                        if (w_countNext == '0) begin
                            r_flushDone <= 1'b1;
                        end else begin
                            r_state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_countNext == '0) begin
                        r_state     <= ST_RUN;
                        r_flushDone <= 1'b1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // Response registers. Forwarded data is captured here; RAM data comes
    // straight from the RAM read register in the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid    <= 1'b0;
            r_err       <= 1'b0;
            r_useFwd    <= 1'b0;
            r_fwdData   <= '0;
            r_rdataHold <= '0;
        end else begin
            r_rvalid    <= w_rdAcc;
            r_err       <= w_accept & ~w_aligned;
            r_useFwd    <= w_hit;
            r_rdataHold <= rdata;
            if (w_rdAcc & w_hit) begin
                r_fwdData <= w_hitData;
            end
        end
    end

    // Outside a response cycle the last returned word is held.
    assign rdata      = r_rvalid ? (r_useFwd ? r_fwdData : w_ramDout) : r_rdataHold;
    assign rvalid     = r_rvalid;
    assign err        = r_err;
    assign flush_done = r_flushDone;

endmodule

// File: tb/tb_dmem_resp.sv
// ---------------------------------------------------------------------------
// tb_dmem_resp -- self-checking bench for dmem_resp.
//
// A transaction-level model keeps the posted writes as a queue and memory as
// a plain array; every cycle it predicts ready, and after the edge rvalid,
// rdata, err and flush_done.
// ---------------------------------------------------------------------------
module tb_dmem_resp;

    localparam int AW    = 4;
    localparam int WORDS = 1 << AW;

    logic        clk = 1'b0;
    logic        rst;
    logic        dm_cs;
    logic        dm_r;
    logic        dm_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        flush;
    logic        ready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;
    logic        flush_done;

    always #5 clk = ~clk;

    dmem_resp #(
        .AW(AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dm_cs      (dm_cs),
        .dm_r       (dm_r),
        .dm_w       (dm_w),
        .addr       (addr),
        .wdata      (wdata),
        .flush      (flush),
        .ready      (ready),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .err        (err),
        .flush_done (flush_done)
    );

    typedef struct {
        int unsigned word;
        logic [31:0] data;
    } entry_t;

    entry_t      mBuf[$];
    logic [31:0] mMem [WORDS];
    bit          mFlushing;
    logic [31:0] mRdata;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Hold reset for two edges, then check the reset state of the outputs.
    task automatic doReset();
        @(negedge clk);
        rst   = 1'b1;
        dm_cs = 1'b0;
        dm_r  = 1'b0;
        dm_w  = 1'b0;
        flush = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        mBuf.delete();
        mFlushing = 1'b0;
        mRdata    = '0;
        #1;
        checkOutput("reset_rvalid", 32'(rvalid), 32'd0);
        checkOutput("reset_rdata", rdata, 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_flush_done", 32'(flush_done), 32'd0);
    endtask

    // One clock cycle of stimulus plus the model step and all output checks.
    task automatic applyStimulus(input logic cs, input logic w, input logic r,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic fl, input string tag);
        logic        expReady;
        logic        acc;
        logic        mis;
        logic        rd;
        logic        wr;
        logic        hit;
        logic        expDone;
        logic [31:0] val;
        int unsigned word;

        @(negedge clk);
        rst   = 1'b0;
        dm_cs = cs;
        dm_w  = w;
        dm_r  = r;
        addr  = a;
        wdata = wd;
        flush = fl;
        #1;

        expReady = !(mFlushing || (mBuf.size() == 2 && w));
        checkOutput({tag, "_ready"}, 32'(ready), 32'(expReady));

        acc  = cs && expReady;
        mis  = acc && (a[1:0] != 2'b00);
        rd   = acc && !w && !mis;
        wr   = acc && w && !mis;
        word = 32'(a[AW+1:2]);

        hit = 1'b0;
        val = '0;
        if (rd) begin
            foreach (mBuf[i]) begin
                if (mBuf[i].word == word) begin
                    hit = 1'b1;
                    val = mBuf[i].data;
                end
            end
            if (!hit) val = mMem[word];
        end

        if (!(rd && !hit) && mBuf.size() > 0) begin
            mMem[mBuf[0].word] = mBuf[0].data;
            void'(mBuf.pop_front());
        end
        if (wr) mBuf.push_back('{word, wd});

        expDone = 1'b0;
        if (mFlushing) begin
            if (mBuf.size() == 0) begin
                mFlushing = 1'b0;
                expDone   = 1'b1;
            end
        end else if (fl) begin
            if (mBuf.size() == 0) expDone = 1'b1;
            else mFlushing = 1'b1;
        end
        if (rd) mRdata = val;

        @(posedge clk);
        #1;
        checkOutput({tag, "_rvalid"}, 32'(rvalid), 32'(rd));
        checkOutput({tag, "_rdata"}, rdata, mRdata);
        checkOutput({tag, "_err"}, 32'(err), 32'(mis));
        checkOutput({tag, "_flush_done"}, 32'(flush_done), 32'(expDone));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, "idle");
    endtask

    initial begin
        logic [31:0] a;
        logic        w;
        logic        fl;

        for (int i = 0; i < WORDS; i++) mMem[i] = 'x;
        doReset();

        // Give every RAM word a known value, then flush it all through.
        for (int i = 0; i < WORDS; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, 32'(i * 4), $urandom | 32'h100, 1'b0, "init");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, "init_flush");
        idle(3);

        // Posted write then immediate read of the same word.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "post_wr");
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h10, 32'd0, 1'b0, "post_rd");
        checkOutput("post_rd_value", rdata, 32'hDEADBEEF);
        idle(2);

        // Back-to-back writes with dm_r held high.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h00, 32'h1111, 1'b0, "full_w1");
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h04, 32'h2222, 1'b0, "full_w2");
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h08, 32'h3333, 1'b0, "full_w3");
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h08, 32'd0, 1'b0, "full_rd");
        idle(2);

        // Youngest matching entry wins.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, 32'd1, 1'b0, "young_w1");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, 32'd2, 1'b0, "young_w2");
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h20, 32'd0, 1'b0, "young_rd");
        checkOutput("young_value", rdata, 32'd2);
        idle(2);

        // Misaligned read, then confirm word 0x10 is untouched.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h13, 32'd0, 1'b0, "mis_rd");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 1'b0, "mis_after");
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h10, 32'd0, 1'b0, "mis_check");
        checkOutput("mis_check_value", rdata, 32'hDEADBEEF);

        // Two writes then flush; reads afterwards use the RAM path.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h24, 32'hA5A5_0001, 1'b0, "fl_w1");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h28, 32'hA5A5_0002, 1'b0, "fl_w2");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 1'b1, "fl_req");
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h24, 32'd0, 1'b0, "fl_stall");
        idle(2);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h24, 32'd0, 1'b0, "fl_rd1");
        checkOutput("fl_rd1_value", rdata, 32'hA5A5_0001);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h28, 32'd0, 1'b0, "fl_rd2");
        checkOutput("fl_rd2_value", rdata, 32'hA5A5_0002);

        // Flush with nothing buffered.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 1'b1, "fl_empty");

        // Reset discards a buffered write; RAM keeps its old word.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h30, 32'd5, 1'b0, "rst_wr");
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h30, 32'd0, 1'b0, "rst_rd");

        // Randomized traffic; upper address bits exercise the wrap.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) doReset();
            a = {$urandom_range(0, 255) << 6} | 32'($urandom_range(0, WORDS - 1) << 2);
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            w  = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 15) == 0);
            applyStimulus(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 1)),
                          a, $urandom, fl, "rand");
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
